// File: rtl/life_engine_seq.sv
// -----------------------------------------------------------------------------
// life_engine_seq
//   Game-of-Life engine for a 2^W_BITS x 2^H_BITS board. Each generation is
//   computed sequentially, one cell per clock, with the B3/S23 rule. Edges are
//   either toroidal or treated as dead. A generation starts on a single-step
//   pulse or when the frame-tick divider expires while run=1.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   frame_tick            one pulse per video frame (drives the divider)
//   run                   free-run enable for the divider
//   step                  request exactly one generation
//   wrap                  1 = toroidal neighbourhood, 0 = off-board is dead
//   clear                 zero the board (IDLE only)
//   wr_en/wr_x/wr_y/wr_data  seed write port (IDLE only)
//   rd_x/rd_y/rd_cell     combinational read of the current board
//   busy                  high while a generation is being computed
//   gen_done              one-cycle pulse after each commit
//   gen_count             generations completed (wraps)
//   pop_count             live cells after the last commit
//   stable                last generation left the board unchanged
// -----------------------------------------------------------------------------
module life_engine_seq #(
  parameter int W_BITS         = 3,
  parameter int H_BITS         = 3,
  parameter int FRAMES_PER_GEN = 60,
  parameter int GEN_W          = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     run,
  input  logic                     step,
  input  logic                     wrap,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [W_BITS-1:0]        wr_x,
  input  logic [H_BITS-1:0]        wr_y,
  input  logic                     wr_data,
  input  logic [W_BITS-1:0]        rd_x,
  input  logic [H_BITS-1:0]        rd_y,
  output logic                     rd_cell,
  output logic                     busy,
  output logic                     gen_done,
  output logic [GEN_W-1:0]         gen_count,
  output logic [W_BITS+H_BITS:0]   pop_count,
  output logic                     stable
);

  localparam int IDX_W = W_BITS + H_BITS;
  localparam int SIZE  = 1 << IDX_W;
  localparam int POP_W = IDX_W + 1;
  localparam int FC_W  = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t state_reg, state_next;

  logic [SIZE-1:0]   cur_reg;
  logic [SIZE-1:0]   nxt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [POP_W-1:0]  acc_reg;
  logic              diff_reg;
  logic              wrap_reg;
  logic [FC_W-1:0]   frame_cnt_reg;
  logic              gen_done_reg;
  logic [GEN_W-1:0]  gen_count_reg;
  logic [POP_W-1:0]  pop_count_reg;
  logic              stable_reg;

  logic              frame_last;
  logic              tick_start;
  logic              start_gen;

  logic [W_BITS-1:0] cx;
  logic [H_BITS-1:0] cy;
  logic [8:0]        nb;
  logic [3:0]        nb_count;
  logic              cur_cell;
  logic              new_cell;

  assign frame_last = (frame_cnt_reg == FC_W'(FRAMES_PER_GEN - 1));
  assign tick_start = run & frame_tick & frame_last;

  assign cx = idx_reg[W_BITS-1:0];
  assign cy = idx_reg[IDX_W-1:W_BITS];

  // Neighbourhood taps, one per 3x3 position (centre excluded). Coordinate
  // arithmetic wraps naturally at the power-of-two board size; in non-wrap
  // mode the tap is masked whenever the step crosses an edge.
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nb
      localparam int DX = (gi % 3) - 1;
      localparam int DY = (gi / 3) - 1;
      if (gi == 4) begin : g_centre
        assign nb[gi] = 1'b0;
      end else begin : g_tap
        logic [W_BITS-1:0] nx;
        logic [H_BITS-1:0] ny;
        logic              off;
        assign nx  = cx + W_BITS'(DX);
        assign ny  = cy + H_BITS'(DY);
        assign off = ((DX < 0) && (cx == '0)) || ((DX > 0) && (&cx)) ||
                     ((DY < 0) && (cy == '0)) || ((DY > 0) && (&cy));
        assign nb[gi] = cur_reg[{ny, nx}] & (wrap_reg | ~off);
      end
    end
  endgenerate

  always_comb begin
    nb_count = '0;
    for (int i = 0; i < 9; i++) begin
      nb_count = nb_count + {3'b000, nb[i]};
    end
  end

  assign cur_cell = cur_reg[idx_reg];
  assign new_cell = (nb_count == 4'd3) | (cur_cell & (nb_count == 4'd2));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state; clear outranks a start request in IDLE
  always_comb begin
    state_next = state_reg;
    start_gen  = 1'b0;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        if (!clear && (step || tick_start)) begin
          start_gen  = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (&idx_reg) begin
          state_next = COMMIT;
        end
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_reg       <= '0;
      nxt_reg       <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      diff_reg      <= 1'b0;
      wrap_reg      <= 1'b0;
      frame_cnt_reg <= '0;
      gen_done_reg  <= 1'b0;
      gen_count_reg <= '0;
      pop_count_reg <= '0;
      stable_reg    <= 1'b0;
    end else begin
      gen_done_reg <= (state_reg == COMMIT);

      // Divider keeps counting regardless of state; expiries while busy are lost
      if (run && frame_tick) begin
        frame_cnt_reg <= frame_last ? '0 : frame_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (clear) begin
            cur_reg       <= '0;
            pop_count_reg <= '0;
            stable_reg    <= 1'b0;
          end else if (start_gen) begin
            wrap_reg <= wrap;
            idx_reg  <= '0;
            acc_reg  <= '0;
            diff_reg <= 1'b0;
          end else if (wr_en) begin
            cur_reg[{wr_y, wr_x}] <= wr_data;
            stable_reg            <= 1'b0;
          end
        end
        SCAN: begin
          nxt_reg[idx_reg] <= new_cell;
          acc_reg          <= acc_reg + POP_W'(new_cell);
          diff_reg         <= diff_reg | (new_cell != cur_cell);
          idx_reg          <= idx_reg + 1'b1;
        end
        COMMIT: begin
          cur_reg       <= nxt_reg;
          pop_count_reg <= acc_reg;
          stable_reg    <= ~diff_reg;
          gen_count_reg <= gen_count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_cell   = cur_reg[{rd_y, rd_x}];
  assign gen_done  = gen_done_reg;
  assign gen_count = gen_count_reg;
  assign pop_count = pop_count_reg;
  assign stable    = stable_reg;

endmodule

// File: tb/tb_life_engine_seq.sv
// -----------------------------------------------------------------------------
// tb_life_engine_seq
//   Self-checking bench for life_engine_seq at the default 8x8 size. A
//   reference model computes each generation directly from the B3/S23 rule
//   on a 64-bit board image; directed scenarios are followed by random boards.
// -----------------------------------------------------------------------------
module tb_life_engine_seq;

  logic        clk = 1'b0;
  logic        reset, frame_tick, run, step, wrap, clear, wr_en, wr_data;
  logic [2:0]  wr_x, wr_y, rd_x, rd_y;
  logic        rd_cell, busy, gen_done, stable;
  logic [15:0] gen_count;
  logic [6:0]  pop_count;

  int n_total = 0;
  int n_pass  = 0;
  int gd_cnt  = 0;

  logic [63:0] m_board;
  int          m_gen;
  int          m_pop;
  logic        m_stable;

  life_engine_seq dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .run(run), .step(step),
    .wrap(wrap), .clear(clear), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .busy(busy), .gen_done(gen_done), .gen_count(gen_count),
    .pop_count(pop_count), .stable(stable)
  );

  always #100 clk = ~clk;

  always @(negedge clk) begin
    if (gen_done === 1'b1) gd_cnt++;
  end

  function automatic logic [63:0] life_next(input logic [63:0] b, input bit w);
    logic [63:0] r;
    r = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        int cnt;
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            int nx, ny;
            if (dx == 0 && dy == 0) continue;
            nx = x + dx;
            ny = y + dy;
            if (w) begin
              nx = (nx + 8) % 8;
              ny = (ny + 8) % 8;
            end else if (nx < 0 || nx > 7 || ny < 0 || ny > 7) begin
              continue;
            end
            if (b[ny*8+nx]) cnt++;
          end
        end
        r[y*8+x] = (cnt == 3) || (b[y*8+x] && cnt == 2);
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_board(output logic [63:0] b);
    b = '0;
    for (int i = 0; i < 64; i++) begin
      rd_x = 3'(i % 8);
      rd_y = 3'(i / 8);
      #1;
      b[i] = rd_cell;
    end
  endtask

  task automatic check_state(input string tag);
    logic [63:0] b;
    read_board(b);
    check({tag, ".board"},  b,               m_board);
    check({tag, ".pop"},    64'(pop_count),  64'(m_pop));
    check({tag, ".gen"},    64'(gen_count),  64'(m_gen));
    check({tag, ".stable"}, 64'(stable),     64'(m_stable));
    check({tag, ".busy"},   64'(busy),       64'd0);
  endtask

  task automatic wr(input int x, input int y, input logic v);
    wr_x = 3'(x); wr_y = 3'(y); wr_data = v; wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    m_board[y*8+x] = v;
    m_stable = 1'b0;
  endtask

  task automatic load(input logic [63:0] b);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    m_board = '0; m_pop = 0; m_stable = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) wr(i % 8, i / 8, 1'b1);
    end
  endtask

  task automatic model_gen(input bit w);
    logic [63:0] nb;
    nb = life_next(m_board, w);
    m_stable = (nb == m_board);
    m_board  = nb;
    m_pop    = $countones(nb);
    m_gen++;
  endtask

  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (gen_done !== 1'b1 && lat < 300) begin
      cyc();
      lat++;
    end
  endtask

  task automatic gen(input bit w, input string tag);
    int lat;
    wrap = w; step = 1'b1;
    cyc();
    step = 1'b0;
    check({tag, ".busy_start"}, 64'(busy), 64'd1);
    wait_done(1, lat);
    check({tag, ".latency"}, 64'(lat), 64'd66);
    model_gen(w);
    check_state(tag);
  endtask

  initial begin
    logic [63:0] b;
    int lat, gd0, g0;

    reset = 1'b1; frame_tick = 0; run = 0; step = 0; wrap = 0; clear = 0;
    wr_en = 0; wr_x = 0; wr_y = 0; wr_data = 0; rd_x = 0; rd_y = 0;
    m_board = '0; m_gen = 0; m_pop = 0; m_stable = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    check_state("reset");
    check("reset.gen_done", 64'(gen_done), 64'd0);

    // Blinker, no wrap: vertical -> horizontal -> vertical
    load(64'h0000_0008_0808_0000);
    gen(1'b0, "t1.g1");
    read_board(b);
    check("t1.horiz", b, 64'h0000_0000_1C00_0000);
    gen(1'b0, "t1.g2");
    read_board(b);
    check("t1.vert", b, 64'h0000_0008_0808_0000);

    // Block still life
    load(64'h303);
    gen(1'b0, "t2");
    check("t2.stable", 64'(stable), 64'd1);

    // Blinker straddling the left/right edge
    load(64'h0000_0000_8300_0000);
    gen(1'b1, "t3.wrap");
    read_board(b);
    check("t3.wrapboard", b, 64'h0000_0001_0101_0000);
    // Reseed by writes only: pop_count must keep the committed value
    wr(0, 2, 1'b0); wr(0, 4, 1'b0); wr(7, 3, 1'b1); wr(1, 3, 1'b1);
    check("t3.pop_after_wr", 64'(pop_count), 64'd3);
    check("t3.stable_after_wr", 64'(stable), 64'd0);
    gen(1'b0, "t3.nowrap");
    check("t3.empty_pop", 64'(pop_count), 64'd0);

    // Writes and clear during SCAN are dropped; display holds old board
    load(64'h0000_0008_0808_0000);
    wrap = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0;
    wr_x = 3'd5; wr_y = 3'd5; wr_data = 1'b1; wr_en = 1'b1; clear = 1'b1;
    cyc();
    wr_en = 1'b0; clear = 1'b0;
    read_board(b);
    check("t5.scan_board", b, m_board);
    wait_done(2, lat);
    check("t5.latency", 64'(lat), 64'd66);
    model_gen(1'b0);
    check_state("t5");

    // Random boards, three generations each
    for (int s = 0; s < 6; s++) begin
      logic [63:0] rb;
      bit w;
      for (int i = 0; i < 64; i++) rb[i] = ($urandom_range(0, 99) < 35);
      w = 1'($urandom_range(0, 1));
      load(rb);
      for (int g = 0; g < 3; g++) gen(w, $sformatf("rnd%0d.%0d", s, g));
    end

    // Reset in the middle of SCAN (idx 20)
    wrap = 1'b1; step = 1'b1;
    cyc();
    step = 1'b0;
    repeat (20) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    m_board = '0; m_gen = 0; m_pop = 0; m_stable = 1'b0;
    check_state("t6");
    check("t6.gen_done", 64'(gen_done), 64'd0);

    // Frame-tick divider, run=1 then run=0
    load(64'h0000_0008_0808_0000);
    wrap = 1'b0; run = 1'b1;
    gd0 = gd_cnt;
    for (int t = 1; t <= 120; t++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc(); cyc();
      if (t == 59) check("t4.before60", 64'(gd_cnt - gd0), 64'd0);
    end
    repeat (80) cyc();
    check("t4.run_gens", 64'(gd_cnt - gd0), 64'd2);
    model_gen(1'b0);
    model_gen(1'b0);
    check_state("t4.run");
    run = 1'b0;
    gd0 = gd_cnt;
    g0  = m_gen;
    for (int t = 1; t <= 120; t++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc(); cyc();
    end
    repeat (80) cyc();
    check("t4.norun_gens", 64'(gd_cnt - gd0), 64'd0);
    check("t4.norun_gen_count", 64'(gen_count), 64'(g0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
